// File: rtl/data_memory_hs_if.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_hs_if
// Purpose  : CPU load/store request/response channels and the loader
//            word-write port of data_memory_hs, grouped into one bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface data_memory_hs_if;
    // CPU request channel (valid/ready)
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_bytes;
    logic        req_we;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    // CPU response channel (registered, back-pressured)
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_we;
    logic        rsp_err;
    // Loader port: full-word writes, no handshake
    logic [31:0] addr_b;
    logic [31:0] din_b;
    logic        we_b;

    modport master (
        output req_valid, req_addr, req_bytes, req_we, req_unsigned, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_we, rsp_err,
        output rsp_ready,
        output addr_b, din_b, we_b
    );

    modport slave (
        input  req_valid, req_addr, req_bytes, req_we, req_unsigned, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_we, rsp_err,
        input  rsp_ready,
        input  addr_b, din_b, we_b
    );
endinterface
`default_nettype wire

// File: rtl/data_memory_hs.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_hs
// Purpose  : Word-organised data memory with a valid/ready CPU load/store
//            port (1-cycle registered response, byte lanes, sub-word loads,
//            error reporting) and a loader full-word write port.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_hs #(
    parameter int DEPTH  = 12,     // log2 of the word count
    parameter bit B_WINS = 1'b1    // loader wins a same-word same-cycle write
) (
    input  wire logic         clk,
    input  wire logic         reset,   // asynchronous, active low
    data_memory_hs_if.slave   bus
);

    localparam int         c_words   = 1 << DEPTH;
    localparam logic [1:0] c_sz_word = 2'b00;
    localparam logic [1:0] c_sz_byte = 2'b01;
    localparam logic [1:0] c_sz_half = 2'b10;

    logic [31:0] mem_q [c_words];
    logic [31:0] rd_word_q;

    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_we_q,    rsp_we_d;
    logic        rsp_err_q,   rsp_err_d;
    logic        rsp_uns_q,   rsp_uns_d;
    logic [1:0]  rsp_size_q,  rsp_size_d;
    logic [1:0]  rsp_off_q,   rsp_off_d;

    logic             w_ready;
    logic             w_accept;
    logic             w_misaligned;
    logic             w_out_of_range;
    logic             w_err;
    logic             w_a_write;
    logic             w_b_override;
    logic [DEPTH-1:0] w_idx_a;
    logic [DEPTH-1:0] w_idx_b;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata_rep;
    logic [31:0]      w_shifted;
    logic [31:0]      w_ext;
    logic             w_unused_b;

    // Single response register: a new request fits whenever it is empty or draining.
    // Accepts are suppressed while reset is held so no store lands during reset.
    assign w_ready  = !rsp_valid_q || bus.rsp_ready;
    assign w_accept = bus.req_valid && w_ready && reset;

    assign w_misaligned   = ((bus.req_bytes == c_sz_half) && bus.req_addr[0]) ||
                            ((bus.req_bytes == c_sz_word) && (bus.req_addr[1:0] != 2'b00));
    assign w_out_of_range = (bus.req_addr >> (DEPTH + 2)) != 32'd0;
    assign w_err          = w_misaligned || w_out_of_range || (bus.req_bytes == 2'b11);

    assign w_idx_a      = bus.req_addr[DEPTH+1:2];
    assign w_idx_b      = bus.addr_b[DEPTH+1:2];
    assign w_a_write    = w_accept && bus.req_we && !w_err;
    assign w_b_override = B_WINS && bus.we_b && (w_idx_a == w_idx_b);

    // Loader address bits outside the word index are ignored by design.
    assign w_unused_b = ^{bus.addr_b[31:DEPTH+2], bus.addr_b[1:0]};

    // Byte-lane enables and lane-replicated store data for the CPU port
    always_comb begin
        w_be        = 4'b0000;
        w_wdata_rep = bus.req_wdata;
        case (bus.req_bytes)
            c_sz_byte: begin
                w_be[bus.req_addr[1:0]] = 1'b1;
                w_wdata_rep             = {4{bus.req_wdata[7:0]}};
            end
            c_sz_half: begin
                w_be        = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{bus.req_wdata[15:0]}};
            end
            c_sz_word: w_be = 4'b1111;
            default:   w_be = 4'b0000;
        endcase
    end

    // Storage: read-first sync read on accept, loader write, then CPU lanes
    // (later assignment wins, so CPU lanes overwrite loader data unless B wins)
    always_ff @(posedge clk) begin
        if (w_accept) begin
            rd_word_q <= mem_q[w_idx_a];
        end
        if (bus.we_b) begin
            mem_q[w_idx_b] <= bus.din_b;
        end
        for (int l = 0; l < 4; l++) begin
            if (w_a_write && w_be[l] && !w_b_override) begin
                mem_q[w_idx_a][8*l +: 8] <= w_wdata_rep[8*l +: 8];
            end
        end
    end

    // Response register next state: load on accept, drop when consumed, else hold
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_we_d    = rsp_we_q;
        rsp_err_d   = rsp_err_q;
        rsp_uns_d   = rsp_uns_q;
        rsp_size_d  = rsp_size_q;
        rsp_off_d   = rsp_off_q;
        if (w_accept) begin
            rsp_valid_d = 1'b1;
            rsp_we_d    = bus.req_we;
            rsp_err_d   = w_err;
            rsp_uns_d   = bus.req_unsigned;
            rsp_size_d  = bus.req_bytes;
            rsp_off_d   = bus.req_addr[1:0];
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_uns_q   <= 1'b0;
            rsp_size_q  <= 2'b00;
            rsp_off_q   <= 2'b00;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_err_q   <= rsp_err_d;
            rsp_uns_q   <= rsp_uns_d;
            rsp_size_q  <= rsp_size_d;
            rsp_off_q   <= rsp_off_d;
        end
    end

    // Load alignment and extension from the registered word and request fields
    always_comb begin
        w_shifted = rd_word_q >> {rsp_off_q, 3'b000};
        case (rsp_size_q)
            c_sz_byte: w_ext = {{24{!rsp_uns_q && w_shifted[7]}},  w_shifted[7:0]};
            c_sz_half: w_ext = {{16{!rsp_uns_q && w_shifted[15]}}, w_shifted[15:0]};
            c_sz_word: w_ext = rd_word_q;
            default:   w_ext = 32'd0;
        endcase
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_we    = rsp_we_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = (rsp_valid_q && !rsp_we_q && !rsp_err_q) ? w_ext : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_hs
// Purpose  : Self-checking bench for data_memory_hs; two instances (B_WINS=1
//            and B_WINS=0) share stimulus and are compared against a
//            byte-addressed reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_hs;

    localparam int DEPTH = 12;
    localparam int MEMB  = 1 << (DEPTH + 2);   // bytes in the memory

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_memory_hs_if if1 ();
    data_memory_hs_if if0 ();

    data_memory_hs #(.DEPTH(DEPTH), .B_WINS(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    data_memory_hs #(.DEPTH(DEPTH), .B_WINS(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));

    assign if0.req_valid    = if1.req_valid;
    assign if0.req_addr     = if1.req_addr;
    assign if0.req_bytes    = if1.req_bytes;
    assign if0.req_we       = if1.req_we;
    assign if0.req_unsigned = if1.req_unsigned;
    assign if0.req_wdata    = if1.req_wdata;
    assign if0.rsp_ready    = if1.rsp_ready;
    assign if0.addr_b       = if1.addr_b;
    assign if0.din_b        = if1.din_b;
    assign if0.we_b         = if1.we_b;

    int checks = 0;
    int errors = 0;

    // Reference model: byte-addressed memories for each collision policy
    bit [7:0]    m1 [MEMB];
    bit [7:0]    m0 [MEMB];
    bit          kn [MEMB];
    bit          e_valid, e_we, e_err, e_known;
    logic [31:0] e_d1, e_d0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] by);
        return (by == 2'b01) ? 1 : (by == 2'b10) ? 2 : 4;
    endfunction

    function automatic logic [31:0] rd(input bit which, input logic [31:0] a,
                                       input logic [1:0] by, input bit uns);
        logic [31:0] v = 32'd0;
        int n = nbytes(by);
        for (int i = 0; i < n; i++) v[8*i +: 8] = which ? m1[a+i] : m0[a+i];
        if (n == 1 && !uns && v[7])  v = v | 32'hFFFF_FF00;
        if (n == 2 && !uns && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    // Advance the model across one clock edge using the inputs now applied
    task automatic model_edge();
        bit          rdy, acc, err, known;
        logic [31:0] a, base;
        logic [1:0]  by;
        int          n;
        a    = if1.req_addr;
        by   = if1.req_bytes;
        n    = nbytes(by);
        rdy  = !e_valid || if1.rsp_ready;
        acc  = if1.req_valid && rdy;
        err  = (by == 2'b11) || (by == 2'b10 && a[0]) || (by == 2'b00 && a[1:0] != 2'b00) ||
               (a >= MEMB);
        base = if1.addr_b & (MEMB - 4);
        if (acc) begin
            e_valid = 1'b1;
            e_we    = if1.req_we;
            e_err   = err;
            if (!err && !if1.req_we) begin
                e_d1  = rd(1'b1, a, by, if1.req_unsigned);
                e_d0  = rd(1'b0, a, by, if1.req_unsigned);
                known = 1'b1;
                for (int i = 0; i < n; i++) known = known && kn[a+i];
                e_known = known;
            end else begin
                e_d1 = 32'd0; e_d0 = 32'd0; e_known = 1'b1;
            end
        end else if (e_valid && if1.rsp_ready) begin
            e_valid = 1'b0;
        end
        // B_WINS=1: CPU lanes first, then the loader word overrides
        if (acc && if1.req_we && !err)
            for (int i = 0; i < n; i++) begin m1[a+i] = if1.req_wdata[8*i +: 8]; kn[a+i] = 1'b1; end
        if (if1.we_b)
            for (int i = 0; i < 4; i++) begin
                m1[base+i] = if1.din_b[8*i +: 8];
                m0[base+i] = if1.din_b[8*i +: 8];
                kn[base+i] = 1'b1;
            end
        // B_WINS=0: CPU lanes land on top of the loader word
        if (acc && if1.req_we && !err)
            for (int i = 0; i < n; i++) m0[a+i] = if1.req_wdata[8*i +: 8];
    endtask

    task automatic check_outputs();
        chk("rsp_valid_b1", if1.rsp_valid, e_valid);
        chk("rsp_valid_b0", if0.rsp_valid, e_valid);
        if (e_valid) begin
            chk("rsp_we", if1.rsp_we, e_we);
            chk("rsp_err_b1", if1.rsp_err, e_err);
            chk("rsp_err_b0", if0.rsp_err, e_err);
            if (e_known) begin
                chk("rsp_rdata_b1", if1.rsp_rdata, e_d1);
                chk("rsp_rdata_b0", if0.rsp_rdata, e_d0);
            end
        end
    endtask

    // One clock: apply inputs, check ready, step model, check registered outputs
    task automatic step(input bit v, input bit we, input bit uns, input logic [1:0] by,
                        input logic [31:0] a, input logic [31:0] wd, input bit rr,
                        input bit wb, input logic [31:0] ab, input logic [31:0] db);
        if1.req_valid    = v;
        if1.req_we       = we;
        if1.req_unsigned = uns;
        if1.req_bytes    = by;
        if1.req_addr     = a;
        if1.req_wdata    = wd;
        if1.rsp_ready    = rr;
        if1.we_b         = wb;
        if1.addr_b       = ab;
        if1.din_b        = db;
        #1;
        chk("req_ready_b1", if1.req_ready, !e_valid || rr);
        chk("req_ready_b0", if0.req_ready, !e_valid || rr);
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
    endtask
    task automatic ld(input logic [1:0] by, input logic [31:0] a, input bit uns);
        step(1'b1, 1'b0, uns, by, a, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
    endtask
    task automatic st(input logic [1:0] by, input logic [31:0] a, input logic [31:0] wd);
        step(1'b1, 1'b1, 1'b0, by, a, wd, 1'b1, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] held, w0;
        reset = 1'b0;
        if1.req_valid = 1'b0; if1.req_we = 1'b0; if1.req_unsigned = 1'b0;
        if1.req_bytes = 2'b00; if1.req_addr = 32'd0; if1.req_wdata = 32'd0;
        if1.rsp_ready = 1'b1; if1.we_b = 1'b0; if1.addr_b = 32'd0; if1.din_b = 32'd0;
        e_valid = 1'b0; e_we = 1'b0; e_err = 1'b0; e_known = 1'b0; e_d1 = 32'd0; e_d0 = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid", if1.rsp_valid, 32'd0);
        chk("reset_rsp_rdata", if1.rsp_rdata, 32'd0);
        chk("reset_rsp_we",    if1.rsp_we,    32'd0);
        chk("reset_rsp_err",   if1.rsp_err,   32'd0);
        chk("reset_req_ready", if1.req_ready, 32'd1);
        reset = 1'b1;

        // Preload bytes 0x00..0xFF through the loader port
        for (int i = 0; i < 64; i++)
            step(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, 32'(i * 4), $urandom);

        // Async reset asserted while a response is stalled
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("stall_valid_before_reset", if1.rsp_valid, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("async_reset_valid_b1", if1.rsp_valid, 32'd0);
        chk("async_reset_valid_b0", if0.rsp_valid, 32'd0);
        chk("async_reset_rdata",    if1.rsp_rdata, 32'd0);
        e_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;

        // Word store / load
        st(2'b00, 32'h10, 32'hDEADBEEF);
        ld(2'b00, 32'h10, 1'b0);
        chk("word_load", if1.rsp_rdata, 32'hDEADBEEF);
        chk("word_load_err", if1.rsp_err, 32'd0);

        // Sub-word accesses
        st(2'b00, 32'h10, 32'h0);
        st(2'b01, 32'h13, 32'h80);
        ld(2'b01, 32'h13, 1'b0); chk("byte_signed",   if1.rsp_rdata, 32'hFFFFFF80);
        ld(2'b01, 32'h13, 1'b1); chk("byte_unsigned", if1.rsp_rdata, 32'h00000080);
        ld(2'b10, 32'h12, 1'b0); chk("half_signed",   if1.rsp_rdata, 32'hFFFF8000);
        ld(2'b00, 32'h10, 1'b1); chk("word_after_byte", if1.rsp_rdata, 32'h80000000);

        // Errors
        ld(2'b10, 32'h11, 1'b0);
        chk("err_half_mis", if1.rsp_err, 32'd1); chk("err_half_rdata", if1.rsp_rdata, 32'd0);
        w0 = {m1[3], m1[2], m1[1], m1[0]};
        st(2'b00, 32'h02, 32'hCAFEF00D);
        chk("err_word_store", if1.rsp_err, 32'd1);
        ld(2'b00, 32'h00, 1'b0);
        chk("err_store_no_write", if1.rsp_rdata, w0);
        ld(2'b00, 32'h4000, 1'b0); chk("err_range", if1.rsp_err, 32'd1);
        ld(2'b11, 32'h10, 1'b0);   chk("err_size",  if1.rsp_err, 32'd1);

        // Back-pressure: first response held for two cycles
        ld(2'b00, 32'h40, 1'b0);
        held = if1.rsp_rdata;
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h44, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("stall_ready_low", if1.req_ready, 32'd0);
        chk("stall_hold_1", if1.rsp_rdata, held);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h44, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("stall_hold_2", if1.rsp_rdata, held);
        ld(2'b00, 32'h44, 1'b0);
        ld(2'b00, 32'h48, 1'b0);
        idle();
        chk("drain_valid", if1.rsp_valid, 32'd0);

        // Same-word same-cycle collision
        step(1'b1, 1'b1, 1'b0, 2'b01, 32'h20, 32'hAA, 1'b1, 1'b1, 32'h20, 32'h11223344);
        chk("collide_store_err", if1.rsp_err, 32'd0);
        ld(2'b00, 32'h20, 1'b0);
        chk("collide_b_wins", if1.rsp_rdata, 32'h11223344);
        chk("collide_a_wins", if0.rsp_rdata, 32'h112233AA);

        // Read-first against a loader write
        st(2'b00, 32'h30, 32'h55555555);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h30, 32'd0, 1'b1, 1'b1, 32'h30, 32'h12345678);
        chk("read_first_old", if1.rsp_rdata, 32'h55555555);
        ld(2'b00, 32'h30, 1'b0);
        chk("read_after_write", if1.rsp_rdata, 32'h12345678);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic [1:0]  by;
            logic [31:0] a, ab;
            int          r;
            by = 2'($urandom_range(0, 3));
            r  = $urandom_range(0, 9);
            a  = 32'($urandom_range(0, 255));
            if (r < 6)  a = a & ((by == 2'b01) ? 32'hFF : (by == 2'b10) ? 32'hFE : 32'hFC);
            if (r == 9) a = a | 32'h4000;
            ab = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63) << 2) |
                 32'($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 by, a, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                 ab, $urandom);
        end
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_memory_hs.md
Name: data_memory_hs

Overview:
Parametrised successor to the core's single-cycle data memory. Block-RAM-style word-organised store with one CPU load/store port and one word-write loader port. The CPU port uses a valid/ready request channel and a registered response channel with 1-cycle read latency. Adds byte-lane writes without read-modify-write, signed/unsigned sub-word loads, alignment and range error reporting, and response back-pressure.

Parameters:
DEPTH, 12, log2 of word count; memory holds 2**DEPTH 32-bit words; word index = addr[DEPTH+1:2].
B_WINS, 1, on a same-word same-cycle write collision: 1 = port B data wins, 0 = port A data wins.

Ports:
clk  in  1  clock; all state on posedge.
reset  in  1  asynchronous, active-low reset.
req_valid  in  1  CPU request valid.
req_ready  out  1  CPU request ready.
req_addr  in  32  byte address.
req_bytes  in  2  size: 00 word, 01 byte, 10 half, 11 illegal.
req_we  in  1  1 = store, 0 = load.
req_unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
rsp_valid  out  1  response valid.
rsp_ready  in  1  response consumed.
rsp_rdata  out  32  load data, extended; 0 for stores and errors.
rsp_we  out  1  echoes req_we of the request being answered.
rsp_err  out  1  request was misaligned, out of range, or illegal size.
addr_b  in  32  loader byte address, word index addr_b[DEPTH+1:2].
din_b  in  32  loader write data.
we_b  in  1  loader full-word write; always accepted, no handshake.

Behaviour:
- Reset (reset=0, async): rsp_valid=0, rsp_rdata=0, rsp_we=0, rsp_err=0. req_ready follows its formula. Memory contents are not cleared. A pending response is discarded.
- req_ready = !rsp_valid || rsp_ready (combinational; one response register).
- Accept when req_valid && req_ready in cycle N. rsp_valid=1 from cycle N+1 with that request's fields. The response holds stable until rsp_ready=1. If no new accept happens in the cycle rsp_ready is seen, rsp_valid drops.
- Back-to-back: when rsp_valid && rsp_ready && new accept, the response register reloads in the same edge. Full throughput is 1 request/cycle.
- Every accepted request produces exactly one response.
- Error checks, evaluated at accept:
  - misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - out of range: addr[31:DEPTH+2] != 0.
  - illegal size: req_bytes=11.
  - On error: no memory write, rsp_err=1, rsp_rdata=0.
- Store: byte-enable mask from size and addr[1:0].
  - byte: lane addr[1:0].
  - half: lanes {addr[1],0} and {addr[1],1}.
  - word: all lanes.
  - Data is replicated into the lanes (byte to all 4, half to both halves). Only enabled lanes are written at the accept edge.
- Load: the word is read synchronously at the accept edge. The selected lane(s) are shifted to bit 0, then sign- or zero-extended per req_unsigned. Word loads ignore req_unsigned.
- Read-during-write:
  - A load accepted in the same cycle as a port-B write to the same word returns the old word (read-first).
  - A load accepted the cycle after any write to that word returns the new data.
- Write collision, same word, same cycle (A store accepted and we_b=1):
  - B_WINS=1: full din_b is stored; A lanes are dropped. A still gets a normal response, rsp_err=0.
  - B_WINS=0: A-enabled lanes take A data; remaining lanes take din_b.
- Port B: no range check; address bits above the index are ignored. we_b is honoured during stall and whenever reset=1.
- Stall (rsp_valid && !rsp_ready): no accept, no A memory access; the response register is frozen.

Test Plan:
- Reset then word store: reset low mid-stall with rsp_valid=1 -> rsp_valid=0 immediately. Then store 0xDEADBEEF to 0x10, load 0x10 -> rsp_rdata=0xDEADBEEF one cycle after accept, rsp_err=0.
- Sub-word load/store: byte store 0x80 to 0x13 over 0x00000000, then:
  - signed byte load 0x13 -> 0xFFFFFF80;
  - unsigned byte load -> 0x00000080;
  - signed half load 0x12 -> 0xFFFF8000;
  - word load 0x10 -> 0x80000000.
- Errors:
  - half load at 0x11 -> rsp_err=1, rdata 0.
  - word store to 0x02 -> rsp_err=1, memory unchanged.
  - addr 0x00004000 with DEPTH=12 -> rsp_err=1.
  - bytes=11 -> rsp_err=1.
- Back-pressure: 3 back-to-back loads with rsp_ready low for 2 cycles after the first response -> req_ready=0 during the stall, the first response is held stable, all 3 responses arrive in order, no loss or duplication.
- Collision, B_WINS=1: same cycle, A byte store 0xAA to 0x20 and we_b with 0x11223344 to 0x20 -> word 0x20 reads 0x11223344. With B_WINS=0 -> 0x112233AA.
- Read-first: load 0x30 (old 0x55555555) accepted in the same cycle as we_b 0x12345678 to 0x30 -> 0x55555555. A load the next cycle -> 0x12345678.
